mac_psum_accumulator_mc: RTL and testbench
==========================================

# mac_psum_accumulator_mc

Multi-lane, depth-parametrised integer partial-sum accumulator for the INT MAC datapath. It sits between the MAC array's psum output and the post-processing stage. It adds a bias on the first pass of an accumulation group and accumulates subsequent passes in an internal buffer. On the final pass it streams completed sums out through a valid/ready port. Compared with the single-lane FP32 accumulator, it adds LANES-wide beats, a per-beat bias mode, variable pass length, and pass-length error detection.

## Interface
- LANES, 4, parallel accumulation lanes per beat
- DEPTH, 64, buffer entries (maximum beats per pass)
- DW, 32, lane width, signed two's complement
- AW, $clog2(DEPTH), buffer address width
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous active-low reset
- i_bias_enable  in  1  1: add bias on first pass; 0: first pass starts from 0
- i_bias_mode  in  1  0: one bias beat per group; 1: one bias beat per first-pass psum beat
- o_bias_ready  out  1  bias handshake ready
- i_bias_valid  in  1  bias handshake valid
- i_bias_data  in  LANES*DW  bias, lane k at [k*DW +: DW]
- o_psum_ready  out  1  psum handshake ready
- i_psum_valid  in  1  psum handshake valid
- i_psum_data  in  LANES*DW  psum beat
- i_inter_end  in  1  qualifies the psum beat as the last beat of a pass
- i_accum_end  in  1  qualifies the psum beat as belonging to the final pass of the group
- i_output_ready  in  1  output handshake ready
- o_output_valid  out  1  output handshake valid
- o_output_data  out  LANES*DW  completed sums
- o_output_last  out  1  marks the last output beat of a group
- o_len_err  out  1  sticky pass-length mismatch flag

## Operation
- Fire events:
  - psum fire = i_psum_valid & o_psum_ready.
  - bias fire = i_bias_valid & o_bias_ready.
- i_bias_enable and i_bias_mode are sampled on entry to S_BIAS or S_FIRST and held for the group.
- State S_BIAS (entered when enable=1 and mode=0):
  - o_bias_ready=1, o_psum_ready=0.
  - Bias fire latches bias_reg and moves to S_FIRST.
- State S_FIRST:
  - Entered directly from reset or group end when enable=0 or mode=1.
  - Each beat computes init + psum. init is bias_reg (mode 0), i_bias_data (mode 1), or 0 (enable=0).
  - Mode 1: psum and bias fire together. o_psum_ready additionally requires i_bias_valid; o_bias_ready = psum-side readiness & i_psum_valid.
- State S_ACCUM: each beat computes buf[addr] + psum.
- Result routing, by i_accum_end on that beat:
  - 0: result is written to buf[addr].
  - 1: result is loaded into the output register.
  - i_accum_end must be constant across a pass.
- addr starts at 0 for every pass and increments per psum fire.
- End of pass is a beat with i_inter_end=1 or addr==DEPTH-1 (forced end). At end of pass:
  - In S_FIRST, pass_len = addr+1 is recorded.
  - addr returns to 0.
  - If accum_end: o_output_last is set with that beat's output, and the state goes to S_BIAS or S_FIRST (group done).
  - Else from S_FIRST: go to S_ACCUM.
- In S_ACCUM, an end of pass at addr != pass_len-1, or reaching pass_len-1 without i_inter_end, sets o_len_err. o_len_err is sticky until reset; it is not cleared by group end. Processing continues with the received beat count.
- Arithmetic is lane-wise DW-bit add; default wraps modulo 2^DW.
- Buffer is flop-array; combinational read of buf[addr], written at psum fire.

## Timing
- Reset values:
  - State S_BIAS if i_bias_enable & ~i_bias_mode, else S_FIRST.
  - addr=0, pass_len=0, bias_reg=0.
  - o_output_valid=0, o_output_data=0, o_output_last=0, o_len_err=0.
  - o_bias_ready and o_psum_ready follow state combinationally.
  - Buffer contents are not reset.
- Latency: psum fire at cycle t → o_output_valid=1 at t+1, registered.
- Output register:
  - Holds data and last until i_output_ready & o_output_valid.
  - Final-pass o_psum_ready = ~o_output_valid | i_output_ready, giving 1 beat/cycle at full ready.
  - Non-final passes are never back-pressured by the output.
- Buffer write at t is readable by the next pass's beat at any cycle ≥ t+1. Single-beat passes (pass_len=1) are legal back-to-back.
- Reset mid-group: the group is abandoned; partial buffer contents are ignored (the next group's first pass overwrites them).
- Valid/data on all inputs must hold until fire; o_output_valid never drops without a fire.

## Configuration
- MAC_PSUM_ACCUM_SAT_EN defined: each lane add saturates to [-2^(DW-1), 2^(DW-1)-1] on signed overflow, in both bias-add and accumulate.
- Undefined: wrap-around two's complement add.

## Test plan
- LANES=4, DW=32, mode 0:
  - Stimulus: bias=10; pass A of 64 beats with psum=k; pass B (accum_end) of 64 beats with psum=2k.
  - Response: 64 outputs with every lane = 10+3k; last only on k=63; o_len_err=0.
- Mode 1, enable=1:
  - Stimulus: 8-beat first pass with bias_k=k, psum=100; final pass psum=1.
  - Response: lanes = 101+k.
  - Also: psum_valid with bias_valid low is never accepted.
- Enable=0, single final pass of 3 beats, psum=5, random i_output_ready (~33% low):
  - Response: outputs 5,5,5 in order, none dropped or duplicated, last on beat 3.
- Length error:
  - Stimulus: first pass 16 beats, second pass inter_end at beat 12.
  - Response: o_len_err=1 after that beat and stays 1 through following groups.
- Overflow:
  - Stimulus: bias=0x7FFFFFF0, psum=0x20 in one final pass.
  - Response: output 0x7FFFFFFF with MAC_PSUM_ACCUM_SAT_EN, 0x80000010 without.
- Reset mid-group:
  - Stimulus: assert reset after 30 beats of a pass.
  - Response: all outputs at reset values.
  - Follow-up: a new group yields bias+psum with no stale buffer data.

Source files
------------

// File: rtl/mac_psum_accumulator_mc.sv
// Multi-lane integer partial-sum accumulator: bias on the first pass, buffered accumulation, streamed final sums.
// Optional MAC_PSUM_ACCUM_SAT_EN: lane adds saturate to the signed DW range instead of wrapping.

module mac_psum_lane_add #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_sum
);
  logic [DW-1:0] w_raw;
  assign w_raw = i_a + i_b;

`ifdef MAC_PSUM_ACCUM_SAT_EN
  logic w_ovf;
  assign w_ovf = (i_a[DW-1] == i_b[DW-1]) && (w_raw[DW-1] != i_a[DW-1]);
  always_comb begin
    o_sum = w_raw;
    if (w_ovf) o_sum = i_a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign o_sum = w_raw;
`endif
endmodule

module mac_psum_accumulator_mc #(
  parameter int LANES = 4,
  parameter int DEPTH = 64,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_bias_enable,
  input  logic                i_bias_mode,
  output logic                o_bias_ready,
  input  logic                i_bias_valid,
  input  logic [LANES*DW-1:0] i_bias_data,
  output logic                o_psum_ready,
  input  logic                i_psum_valid,
  input  logic [LANES*DW-1:0] i_psum_data,
  input  logic                i_inter_end,
  input  logic                i_accum_end,
  input  logic                i_output_ready,
  output logic                o_output_valid,
  output logic [LANES*DW-1:0] o_output_data,
  output logic                o_output_last,
  output logic                o_len_err
);
  typedef enum logic [1:0] {S_BIAS, S_FIRST, S_ACCUM} state_t;

  state_t              r_state, w_state, w_nxt_state;
  logic                r_open, w_nxt_open;
  logic                r_en, r_mode, w_en, w_mode;
  logic [AW-1:0]       r_addr;
  logic [AW:0]         r_pass_len, w_last_idx;
  logic [LANES*DW-1:0] r_bias;
  logic [LANES*DW-1:0] r_buf [DEPTH];
  logic                r_ov, r_ol, r_err;
  logic [LANES*DW-1:0] r_od;
  logic                w_side, w_pfire, w_bfire, w_eop, w_len_bad;
  logic [LANES*DW-1:0] w_opa, w_sum;

  // Until a group commits (bias or first psum fire) the mode inputs are followed live,
  // so reset and group-end land in S_BIAS or S_FIRST according to the current settings.
  always_comb begin
    w_state = r_open ? r_state : ((i_bias_enable & ~i_bias_mode) ? S_BIAS : S_FIRST);
    w_en    = r_open ? r_en   : i_bias_enable;
    w_mode  = r_open ? r_mode : i_bias_mode;
  end

  assign w_side = i_accum_end ? (~r_ov | i_output_ready) : 1'b1;

  always_comb begin
    o_psum_ready = 1'b0;
    o_bias_ready = 1'b0;
    unique case (w_state)
      S_BIAS:  o_bias_ready = 1'b1;
      S_FIRST: begin
        if (w_en & w_mode) begin
          o_psum_ready = w_side & i_bias_valid;
          o_bias_ready = w_side & i_psum_valid;
        end else begin
          o_psum_ready = w_side;
        end
      end
      S_ACCUM: o_psum_ready = w_side;
      default: ;
    endcase
  end

  assign w_pfire    = i_psum_valid & o_psum_ready;
  assign w_bfire    = i_bias_valid & o_bias_ready;
  assign w_eop      = i_inter_end | (r_addr == AW'(DEPTH-1));
  assign w_last_idx = r_pass_len - (AW+1)'(1);
  assign w_len_bad  = (w_eop && ({1'b0, r_addr} != w_last_idx)) ||
                      (!w_eop && ({1'b0, r_addr} == w_last_idx));

  always_comb begin
    if (w_state == S_ACCUM)  w_opa = r_buf[r_addr];
    else if (!w_en)          w_opa = '0;
    else if (w_mode)         w_opa = i_bias_data;
    else                     w_opa = r_bias;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_psum_lane_add #(.DW(DW)) u_add (
      .i_a   (w_opa[g*DW +: DW]),
      .i_b   (i_psum_data[g*DW +: DW]),
      .o_sum (w_sum[g*DW +: DW])
    );
  end

  always_comb begin
    w_nxt_state = w_state;
    w_nxt_open  = r_open;
    unique case (w_state)
      S_BIAS: begin
        if (w_bfire) begin
          w_nxt_state = S_FIRST;
          w_nxt_open  = 1'b1;
        end
      end
      S_FIRST: begin
        if (w_pfire) begin
          w_nxt_open = 1'b1;
          if (w_eop) begin
            if (i_accum_end) w_nxt_open  = 1'b0;
            else             w_nxt_state = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (w_pfire && w_eop && i_accum_end) w_nxt_open = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_FIRST;
      r_open     <= 1'b0;
      r_en       <= 1'b0;
      r_mode     <= 1'b0;
      r_addr     <= '0;
      r_pass_len <= '0;
      r_bias     <= '0;
      r_ov       <= 1'b0;
      r_od       <= '0;
      r_ol       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_open  <= w_nxt_open;
      if (!r_open && w_nxt_open) begin
        r_en   <= i_bias_enable;
        r_mode <= i_bias_mode;
      end
      if (w_bfire && w_state == S_BIAS) r_bias <= i_bias_data;
      if (w_pfire) begin
        r_addr <= w_eop ? '0 : r_addr + AW'(1);
        if (w_state == S_FIRST && w_eop) r_pass_len <= (AW+1)'(r_addr) + (AW+1)'(1);
        if (w_state == S_ACCUM && w_len_bad) r_err <= 1'b1;
      end
      if (w_pfire && i_accum_end) begin
        r_ov <= 1'b1;
        r_od <= w_sum;
        r_ol <= w_eop;
      end else if (r_ov && i_output_ready) begin
        r_ov <= 1'b0;
      end
    end
  end

  // Buffer is deliberately not reset; a new group's first pass overwrites what it reads later.
  always_ff @(posedge i_clk) begin
    if (w_pfire && !i_accum_end) r_buf[r_addr] <= w_sum;
  end

  assign o_output_valid = r_ov;
  assign o_output_data  = r_od;
  assign o_output_last  = r_ol;
  assign o_len_err      = r_err;
endmodule

// File: tb/tb_mac_psum_accumulator_mc.sv
// Directed bench for mac_psum_accumulator_mc (LANES=4, DEPTH=64, DW=32).
module tb_mac_psum_accumulator_mc;
  logic         i_clk = 1'b0;
  logic         i_reset, i_bias_enable, i_bias_mode;
  logic         o_bias_ready, i_bias_valid;
  logic [127:0] i_bias_data;
  logic         o_psum_ready, i_psum_valid;
  logic [127:0] i_psum_data;
  logic         i_inter_end, i_accum_end;
  logic         i_output_ready = 1'b1;
  logic         o_output_valid;
  logic [127:0] o_output_data;
  logic         o_output_last, o_len_err;

  int tests = 0;
  int fails = 0;
  bit rnd_rdy = 1'b0;
  logic [127:0] q_data [$];
  logic         q_last [$];

  mac_psum_accumulator_mc dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_bias_enable(i_bias_enable), .i_bias_mode(i_bias_mode),
    .o_bias_ready(o_bias_ready), .i_bias_valid(i_bias_valid), .i_bias_data(i_bias_data),
    .o_psum_ready(o_psum_ready), .i_psum_valid(i_psum_valid), .i_psum_data(i_psum_data),
    .i_inter_end(i_inter_end), .i_accum_end(i_accum_end),
    .i_output_ready(i_output_ready), .o_output_valid(o_output_valid),
    .o_output_data(o_output_data), .o_output_last(o_output_last), .o_len_err(o_len_err)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) i_output_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;

  always @(posedge i_clk)
    if (i_reset && o_output_valid && i_output_ready) begin
      q_data.push_back(o_output_data);
      q_last.push_back(o_output_last);
    end

  function automatic logic [127:0] rep(input logic [31:0] v);
    return {4{v}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic psum_beat(input logic [127:0] d, input logic ie, input logic ae,
                           input logic bv, input logic [127:0] bd);
    int n = 0;
    @(negedge i_clk);
    i_psum_valid = 1'b1; i_psum_data = d; i_inter_end = ie; i_accum_end = ae;
    i_bias_valid = bv; i_bias_data = bd;
    #1;
    while (!o_psum_ready && n < 200) begin @(negedge i_clk); #1; n++; end
    if (n >= 200) chk("psum_handshake_timeout", {127'd0, o_psum_ready}, 128'd1);
    @(posedge i_clk); #1;
    i_psum_valid = 1'b0; i_bias_valid = 1'b0;
  endtask

  task automatic bias_beat(input logic [127:0] bd);
    int n = 0;
    @(negedge i_clk);
    i_bias_valid = 1'b1; i_bias_data = bd;
    #1;
    while (!o_bias_ready && n < 200) begin @(negedge i_clk); #1; n++; end
    if (n >= 200) chk("bias_handshake_timeout", {127'd0, o_bias_ready}, 128'd1);
    @(posedge i_clk); #1;
    i_bias_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int c = 0;
    while (q_data.size() < n && c < 500) begin @(negedge i_clk); c++; end
    chk("output_count", 128'(q_data.size()), 128'(n));
  endtask

  initial begin
    logic [31:0] ovf_exp;
    i_reset = 1'b0; i_bias_enable = 1'b1; i_bias_mode = 1'b0;
    i_bias_valid = 1'b0; i_bias_data = '0; i_psum_valid = 1'b0; i_psum_data = '0;
    i_inter_end = 1'b0; i_accum_end = 1'b0;
    #2;
    chk("rst_out_valid", {127'd0, o_output_valid}, 128'd0);
    chk("rst_out_data", o_output_data, 128'd0);
    chk("rst_out_last", {127'd0, o_output_last}, 128'd0);
    chk("rst_len_err", {127'd0, o_len_err}, 128'd0);
    chk("rst_bias_ready", {127'd0, o_bias_ready}, 128'd1);
    chk("rst_psum_ready", {127'd0, o_psum_ready}, 128'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;

    // mode 0: bias 10, pass A psum=k, final pass psum=2k -> 10+3k
    q_data.delete(); q_last.delete();
    bias_beat(rep(32'd10));
    for (int k = 0; k < 64; k++) psum_beat(rep(32'(k)), k == 63, 1'b0, 1'b0, '0);
    for (int k = 0; k < 64; k++) psum_beat(rep(32'(2*k)), k == 63, 1'b1, 1'b0, '0);
    wait_out(64);
    for (int k = 0; k < 64 && k < q_data.size(); k++) begin
      chk($sformatf("m0_data_%0d", k), q_data[k], rep(32'(10 + 3*k)));
      chk($sformatf("m0_last_%0d", k), {127'd0, q_last[k]}, {127'd0, k == 63});
    end
    chk("m0_len_err", {127'd0, o_len_err}, 128'd0);

    // mode 1: psum without bias never accepted; then bias_k=k, psum=100; final psum=1
    q_data.delete(); q_last.delete();
    @(negedge i_clk);
    i_bias_mode = 1'b1; i_psum_valid = 1'b1; i_psum_data = rep(32'd55);
    i_inter_end = 1'b1; i_accum_end = 1'b1; i_bias_valid = 1'b0;
    repeat (3) begin
      #1 chk("m1_no_bias_psum_ready", {127'd0, o_psum_ready}, 128'd0);
      @(negedge i_clk);
    end
    i_psum_valid = 1'b0;
    for (int k = 0; k < 8; k++) psum_beat(rep(32'd100), k == 7, 1'b0, 1'b1, rep(32'(k)));
    for (int k = 0; k < 8; k++) psum_beat(rep(32'd1), k == 7, 1'b1, 1'b0, '0);
    wait_out(8);
    for (int k = 0; k < 8 && k < q_data.size(); k++)
      chk($sformatf("m1_data_%0d", k), q_data[k], rep(32'(101 + k)));
    chk("m1_last", {127'd0, q_last[7]}, 128'd1);

    // enable=0, single final pass with random output backpressure
    q_data.delete(); q_last.delete();
    i_bias_enable = 1'b0; i_bias_mode = 1'b0;
    rnd_rdy = 1'b1;
    for (int k = 0; k < 3; k++) psum_beat(rep(32'd5), k == 2, 1'b1, 1'b0, '0);
    wait_out(3);
    repeat (6) @(negedge i_clk);
    rnd_rdy = 1'b0;
    chk("en0_count_final", 128'(q_data.size()), 128'd3);
    for (int k = 0; k < 3 && k < q_data.size(); k++) begin
      chk($sformatf("en0_data_%0d", k), q_data[k], rep(32'd5));
      chk($sformatf("en0_last_%0d", k), {127'd0, q_last[k]}, {127'd0, k == 2});
    end

    // length error: 16-beat first pass, 12-beat second pass
    q_data.delete(); q_last.delete();
    for (int k = 0; k < 16; k++) psum_beat(rep(32'd1), k == 15, 1'b0, 1'b0, '0);
    chk("len_err_before", {127'd0, o_len_err}, 128'd0);
    for (int k = 0; k < 12; k++) psum_beat(rep(32'd1), k == 11, 1'b0, 1'b0, '0);
    chk("len_err_set", {127'd0, o_len_err}, 128'd1);
    for (int k = 0; k < 12; k++) psum_beat(rep(32'd0), k == 11, 1'b1, 1'b0, '0);
    wait_out(12);
    chk("len_err_accum_k0", q_data[0], rep(32'd2));
    q_data.delete(); q_last.delete();
    psum_beat(rep(32'd9), 1'b1, 1'b1, 1'b0, '0);
    wait_out(1);
    chk("len_err_next_group_data", q_data[0], rep(32'd9));
    chk("len_err_sticky", {127'd0, o_len_err}, 128'd1);

    // overflow on bias add
    q_data.delete(); q_last.delete();
    i_bias_enable = 1'b1;
`ifdef MAC_PSUM_ACCUM_SAT_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h8000_0010;
`endif
    bias_beat(rep(32'h7FFF_FFF0));
    psum_beat(rep(32'h20), 1'b1, 1'b1, 1'b0, '0);
    wait_out(1);
    chk("ovf_data", q_data[0], rep(ovf_exp));
    chk("ovf_last", {127'd0, q_last[0]}, 128'd1);

    // reset mid-group, then a clean two-pass group
    q_data.delete(); q_last.delete();
    bias_beat(rep(32'd7));
    for (int k = 0; k < 30; k++) psum_beat(rep(32'(k)), 1'b0, 1'b0, 1'b0, '0);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, o_output_valid}, 128'd0);
    chk("midrst_out_data", o_output_data, 128'd0);
    chk("midrst_out_last", {127'd0, o_output_last}, 128'd0);
    chk("midrst_len_err", {127'd0, o_len_err}, 128'd0);
    chk("midrst_bias_ready", {127'd0, o_bias_ready}, 128'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    bias_beat(rep(32'd3));
    for (int k = 0; k < 4; k++) psum_beat(rep(32'd1), k == 3, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) psum_beat(rep(32'd2), k == 3, 1'b1, 1'b0, '0);
    wait_out(4);
    for (int k = 0; k < 4 && k < q_data.size(); k++) begin
      chk($sformatf("post_rst_data_%0d", k), q_data[k], rep(32'd6));
      chk($sformatf("post_rst_last_%0d", k), {127'd0, q_last[k]}, {127'd0, k == 3});
    end
    chk("post_rst_len_err", {127'd0, o_len_err}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
